gnn_agg_engine: RTL and testbench

- Aggregation (SpMM) engine of the GNN accelerator kernel.
- Takes one 128-bit instruction, streams an edge list (adjacency) from DRAM, and performs result[dst] += weight * feature[src] per edge.
- Feature rows come from on-chip buffer 0; result rows are read-modify-written in on-chip buffer 1A.
- Sits between the instruction dispatcher and the shared feature/result buffers.

---
 rtl/gnn_agg_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_gnn_agg_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_agg_engine.sv
`default_nettype none
// ============================================================================
// Module   : gnn_agg_engine
// Purpose  : GNN aggregation (SpMM) engine. One 128-bit instruction launches
//            a DRAM read of an edge list; for every valid edge the engine
//            computes result[dst] += weight * feature[src] across all lanes.
//            Edges are processed strictly serially, so repeated dst rows
//            accumulate correctly.
// Ports    : aclk/areset          clock, synchronous active-high reset
//            ap_start/ap_done     one-cycle start / done pulses
//            ctrl_*               instruction and DRAM address offset
//            dram_xfer_*, read_*  DRAM reader launch and completion
//            data_t*              AXI-stream adjacency beats
//            agg_read_buffer_0_*  feature row read (addr = src)
//            agg_read_buffer_1_A_* result row read (addr = dst)
//            agg_write_buffer_1_A_* result row write-back
// Options  : AGG_SAT_EN defined -> product and lane sum saturate to int32;
//            undefined -> two's-complement wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module gnn_agg_engine #(
  parameter int DATA_W         = 512,
  parameter int ADDR_W         = 11,
  parameter int LANES          = 16,
  parameter int EDGES_PER_BEAT = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              ap_start,
  output logic              ap_done,
  input  logic [63:0]       ctrl_addr_offset,
  input  logic [127:0]      ctrl_instruction,
  output logic [63:0]       dram_xfer_start_addr,
  output logic [31:0]       dram_xfer_size_in_bytes,
  output logic              read_start,
  input  logic              read_done,
  input  logic              data_tvalid,
  output logic              data_tready,
  input  logic              data_tlast,
  input  logic [DATA_W-1:0] data_tdata,
  output logic              agg_read_buffer_0_avalid,
  output logic [ADDR_W-1:0] agg_read_buffer_0_addr,
  input  logic              agg_read_buffer_0_valid,
  input  logic [DATA_W-1:0] agg_read_buffer_0_data,
  output logic              agg_read_buffer_1_A_avalid,
  output logic [ADDR_W-1:0] agg_read_buffer_1_A_addr,
  input  logic              agg_read_buffer_1_A_valid,
  input  logic [DATA_W-1:0] agg_read_buffer_1_A_data,
  output logic              agg_write_buffer_1_A_valid,
  output logic [ADDR_W-1:0] agg_write_buffer_1_A_addr,
  output logic [DATA_W-1:0] agg_write_buffer_1_A_data
);

  localparam int EIDX_W = $clog2(EDGES_PER_BEAT);

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT, S_EDGE, S_WAIT, S_WRITE, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d, after_edge;
  logic [63:0]         xfer_addr_q;
  logic [31:0]         xfer_size_q;
  logic                read_start_q;
  logic [DATA_W-1:0]   beat_q;
  logic                last_q;
  logic [EIDX_W-1:0]   edge_idx_q;
  logic [31:0]         beat_cnt_q;
  logic                rd_done_seen_q;
  logic [DATA_W-1:0]   feat_q, res_q;
  logic                feat_ok_q, res_ok_q;
  logic                feat_ok_d, res_ok_d;

  // Edge record decode
  logic [63:0]         edge_rec [EDGES_PER_BEAT];
  logic [63:0]         cur_edge;
  logic [ADDR_W-1:0]   edge_src, edge_dst;
  logic                edge_vld;
  logic [31:0]         edge_w;
  logic [31:0]         beats_needed;
  logic                last_edge, beat_end;
  logic [DATA_W-1:0]   lane_sum;

  for (genvar e = 0; e < EDGES_PER_BEAT; e++) begin : g_edge
    assign edge_rec[e] = beat_q[64*e +: 64];
  end

  assign cur_edge = edge_rec[edge_idx_q];
  assign edge_src = cur_edge[ADDR_W-1:0];
  assign edge_dst = cur_edge[2*ADDR_W-1:ADDR_W];
  assign edge_vld = cur_edge[22];
  assign edge_w   = cur_edge[63:32];

  // Beats expected from the byte count, rounded up to whole 64-byte beats
  assign beats_needed = {6'd0, xfer_size_q[31:6]} + {31'd0, |xfer_size_q[5:0]};
  assign last_edge    = (edge_idx_q == EIDX_W'(EDGES_PER_BEAT - 1));
  assign beat_end     = last_q || (beat_cnt_q == beats_needed);
  assign after_edge   = !last_edge ? S_EDGE : (beat_end ? S_DRAIN : S_BEAT);

  // A return arriving in the same cycle counts as captured for the decision
  assign feat_ok_d = feat_ok_q | agg_read_buffer_0_valid;
  assign res_ok_d  = res_ok_q  | agg_read_buffer_1_A_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] f, r;
    assign f = feat_q[32*i +: 32];
    assign r = res_q[32*i +: 32];
`ifdef AGG_SAT_EN
    logic [63:0] prod;
    logic [31:0] p_sat;
    logic [32:0] sum;
    // Sign-extended operands: the low 64 bits equal the exact signed product
    assign prod  = {{32{edge_w[31]}}, edge_w} * {{32{f[31]}}, f};
    assign p_sat = (&prod[63:31] || ~|prod[63:31]) ? prod[31:0]
                 : (prod[63] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    assign sum   = {r[31], r} + {p_sat[31], p_sat};
    assign lane_sum[32*i +: 32] = (sum[32] != sum[31])
                                ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                : sum[31:0];
`else
    logic [31:0] prod_lo;
    // Low 32 bits of a product are identical for signed and unsigned operands
    assign prod_lo = edge_w * f;
    assign lane_sum[32*i +: 32] = r + prod_lo;
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{ctrl_instruction[127:96], cur_edge[31:23]};

  assign read_start              = read_start_q;
  assign dram_xfer_start_addr    = xfer_addr_q;
  assign dram_xfer_size_in_bytes = xfer_size_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= S_IDLE;
      xfer_addr_q    <= '0;
      xfer_size_q    <= '0;
      read_start_q   <= 1'b0;
      beat_q         <= '0;
      last_q         <= 1'b0;
      edge_idx_q     <= '0;
      beat_cnt_q     <= '0;
      rd_done_seen_q <= 1'b0;
      feat_q         <= '0;
      res_q          <= '0;
      feat_ok_q      <= 1'b0;
      res_ok_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_start_q <= 1'b0;
      if (state_q == S_IDLE && ap_start) begin
        xfer_addr_q    <= ctrl_instruction[63:0] + ctrl_addr_offset;
        xfer_size_q    <= ctrl_instruction[95:64];
        read_start_q   <= |ctrl_instruction[95:64];
        beat_cnt_q     <= '0;
        rd_done_seen_q <= 1'b0;
      end else if (state_q != S_IDLE && read_done) begin
        // read_done may arrive long before the last edge is processed
        rd_done_seen_q <= 1'b1;
      end
      if (state_q == S_BEAT && data_tvalid) begin
        beat_q     <= data_tdata;
        last_q     <= data_tlast;
        beat_cnt_q <= beat_cnt_q + 32'd1;
        edge_idx_q <= '0;
      end
      if (state_q == S_EDGE) begin
        feat_ok_q <= 1'b0;
        res_ok_q  <= 1'b0;
        if (!edge_vld) edge_idx_q <= edge_idx_q + 1'b1;
      end
      if (state_q == S_WAIT) begin
        if (agg_read_buffer_0_valid && !feat_ok_q) begin
          feat_q    <= agg_read_buffer_0_data;
          feat_ok_q <= 1'b1;
        end
        if (agg_read_buffer_1_A_valid && !res_ok_q) begin
          res_q    <= agg_read_buffer_1_A_data;
          res_ok_q <= 1'b1;
        end
      end
      if (state_q == S_WRITE) edge_idx_q <= edge_idx_q + 1'b1;
    end
  end

  always_comb begin
    state_d                    = state_q;
    ap_done                    = 1'b0;
    data_tready                = 1'b0;
    agg_read_buffer_0_avalid   = 1'b0;
    agg_read_buffer_0_addr     = '0;
    agg_read_buffer_1_A_avalid = 1'b0;
    agg_read_buffer_1_A_addr   = '0;
    agg_write_buffer_1_A_valid = 1'b0;
    agg_write_buffer_1_A_addr  = '0;
    agg_write_buffer_1_A_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) state_d = (ctrl_instruction[95:64] == 32'd0) ? S_DONE : S_BEAT;
      end
      S_BEAT: begin
        data_tready = 1'b1;
        if (data_tvalid) state_d = S_EDGE;
      end
      S_EDGE: begin
        if (edge_vld) begin
          agg_read_buffer_0_avalid   = 1'b1;
          agg_read_buffer_0_addr     = edge_src;
          agg_read_buffer_1_A_avalid = 1'b1;
          agg_read_buffer_1_A_addr   = edge_dst;
          state_d                    = S_WAIT;
        end else begin
          state_d = after_edge;
        end
      end
      S_WAIT: begin
        if (feat_ok_d && res_ok_d) state_d = S_WRITE;
      end
      S_WRITE: begin
        agg_write_buffer_1_A_valid = 1'b1;
        agg_write_buffer_1_A_addr  = edge_dst;
        agg_write_buffer_1_A_data  = lane_sum;
        state_d                    = after_edge;
      end
      S_DRAIN: begin
        if (rd_done_seen_q || read_done) state_d = S_DONE;
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gnn_agg_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gnn_agg_engine
// Purpose  : Self-checking bench for gnn_agg_engine. Models the DRAM stream,
//            the feature/result buffers and the reader, and compares buffer
//            contents against a lane-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gnn_agg_engine;

  localparam int NROW = 64;
`ifdef AGG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint MAXI = 64'sh7FFF_FFFF;
  localparam longint MINI = -64'sh8000_0000;

  logic         aclk = 1'b0;
  logic         areset, ap_start, ap_done;
  logic [63:0]  ctrl_addr_offset;
  logic [127:0] ctrl_instruction;
  logic [63:0]  dram_xfer_start_addr;
  logic [31:0]  dram_xfer_size_in_bytes;
  logic         read_start, read_done;
  logic         data_tvalid, data_tready, data_tlast;
  logic [511:0] data_tdata;
  logic         b0_avalid, b0_valid, b1_avalid, b1_valid, w_valid;
  logic [10:0]  b0_addr, b1_addr, w_addr;
  logic [511:0] b0_data, b1_data, w_data;

  always #5 aclk = ~aclk;

  gnn_agg_engine dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .dram_xfer_start_addr(dram_xfer_start_addr),
    .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
    .read_start(read_start), .read_done(read_done),
    .data_tvalid(data_tvalid), .data_tready(data_tready),
    .data_tlast(data_tlast), .data_tdata(data_tdata),
    .agg_read_buffer_0_avalid(b0_avalid), .agg_read_buffer_0_addr(b0_addr),
    .agg_read_buffer_0_valid(b0_valid), .agg_read_buffer_0_data(b0_data),
    .agg_read_buffer_1_A_avalid(b1_avalid), .agg_read_buffer_1_A_addr(b1_addr),
    .agg_read_buffer_1_A_valid(b1_valid), .agg_read_buffer_1_A_data(b1_data),
    .agg_write_buffer_1_A_valid(w_valid), .agg_write_buffer_1_A_addr(w_addr),
    .agg_write_buffer_1_A_data(w_data)
  );

  int n_pass = 0, n_total = 0;

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge aclk);
  endtask

  // ---------------- buffer memories and reader model ----------------
  logic [511:0] feat_mem [NROW];
  logic [511:0] res_mem  [NROW];
  logic [511:0] gold     [NROW];
  int lat0 = 4, lat1 = 4;
  int cnt0 = 0, cnt1 = 0;
  logic [511:0] ret0, ret1;
  int n_rs = 0, n_rd0 = 0, n_rd1 = 0, n_wr = 0, n_done = 0;
  logic [10:0]  wr_addr_log [$];
  logic [511:0] wr_data_log [$];
  logic [63:0]  seen_addr;
  logic [31:0]  seen_size;

  initial begin
    b0_valid = 1'b0; b1_valid = 1'b0; b0_data = '0; b1_data = '0;
    forever begin
      @(negedge aclk);
      b0_valid = 1'b0;
      b1_valid = 1'b0;
      if (cnt0 > 0) begin
        cnt0--;
        if (cnt0 == 0) begin b0_valid = 1'b1; b0_data = ret0; end
      end
      if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) begin b1_valid = 1'b1; b1_data = ret1; end
      end
      if (b0_avalid) begin cnt0 = lat0; ret0 = feat_mem[b0_addr[5:0]]; n_rd0++; end
      if (b1_avalid) begin cnt1 = lat1; ret1 = res_mem[b1_addr[5:0]]; n_rd1++; end
      if (w_valid) begin
        res_mem[w_addr[5:0]] = w_data;
        wr_addr_log.push_back(w_addr);
        wr_data_log.push_back(w_data);
        n_wr++;
      end
      if (ap_done) n_done++;
      if (read_start) begin
        n_rs++;
        seen_addr = dram_xfer_start_addr;
        seen_size = dram_xfer_size_in_bytes;
      end
    end
  end

  // ---------------- AXI-stream source and read_done ----------------
  logic [511:0] sq_data [$];
  logic         sq_last [$];
  bit           gaps = 1'b1;
  int           rd_cd = -1;

  initial begin
    bit hs;
    hs = 1'b0;
    data_tvalid = 1'b0; data_tdata = '0; data_tlast = 1'b0; read_done = 1'b0;
    forever begin
      @(negedge aclk);
      read_done = 1'b0;
      if (areset) hs = 1'b0;
      if (hs) begin
        void'(sq_data.pop_front());
        void'(sq_last.pop_front());
        data_tvalid = 1'b0;
        hs = 1'b0;
        if (sq_data.size() == 0) rd_cd = $urandom_range(0, 6);
      end
      if (rd_cd == 0) begin read_done = 1'b1; rd_cd = -1; end
      else if (rd_cd > 0) rd_cd--;
      if (!data_tvalid && sq_data.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
        data_tvalid = 1'b1;
        data_tdata  = sq_data[0];
        data_tlast  = sq_last[0];
      end
      hs = data_tvalid && data_tready;
    end
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] lane_op(logic [31:0] r, logic [31:0] f, logic [31:0] w);
    longint p, s;
    p = longint'($signed(w)) * longint'($signed(f));
    if (SAT) begin
      if (p > MAXI) p = MAXI;
      else if (p < MINI) p = MINI;
    end
    s = longint'($signed(r)) + p;
    if (SAT) begin
      if (s > MAXI) s = MAXI;
      else if (s < MINI) s = MINI;
    end
    return s[31:0];
  endfunction

  function automatic logic [63:0] mk_edge(logic [10:0] s, logic [10:0] d, logic v,
                                          logic [31:0] w, logic [8:0] junk);
    return {w, junk, v, d, s};
  endfunction

  task automatic start(logic [63:0] addr, logic [31:0] size);
    ctrl_instruction = {32'hDEAD_BEEF, size, addr};
    ap_start = 1'b1;
    tick(1);
    ap_start = 1'b0;
  endtask

  // Runs one instruction; checks a single ap_done and the DRAM launch values
  task automatic run(string name, logic [63:0] addr, logic [31:0] size, int budget);
    int d0, rs0, k;
    d0 = n_done; rs0 = n_rs; k = 0;
    start(addr, size);
    tick(3);
    ctrl_instruction = '0;
    ap_start = 1'b1;      // busy: must be ignored
    tick(1);
    ap_start = 1'b0;
    while (n_done == d0 && k < budget) begin tick(1); k++; end
    tick(4);
    check({name, " done once"}, n_done - d0, 1);
    check({name, " read_start count"}, n_rs - rs0, 1);
    check({name, " dram addr"}, seen_addr, addr + ctrl_addr_offset);
    check({name, " dram size"}, seen_size, size);
  endtask

  task automatic random_run(string name, int nbeats, logic [31:0] size, bit use_last);
    logic [511:0] b;
    logic [10:0] s, d;
    logic v;
    logic [31:0] w;
    for (int r = 0; r < NROW; r++) begin
      for (int l = 0; l < 16; l++) begin
        feat_mem[r][32*l +: 32] = $urandom;
        res_mem[r][32*l +: 32]  = $urandom;
      end
      gold[r] = res_mem[r];
    end
    for (int bi = 0; bi < nbeats; bi++) begin
      b = '0;
      for (int ei = 0; ei < 8; ei++) begin
        s = 11'($urandom_range(0, NROW - 1));
        d = 11'($urandom_range(0, 15));
        v = ($urandom_range(0, 4) != 0);
        w = $urandom_range(0, 1) ? $urandom : ($urandom_range(0, 20) - 10);
        b[64*ei +: 64] = mk_edge(s, d, v, w, 9'($urandom));
        if (v)
          for (int l = 0; l < 16; l++)
            gold[d][32*l +: 32] = lane_op(gold[d][32*l +: 32], feat_mem[s][32*l +: 32], w);
      end
      sq_data.push_back(b);
      sq_last.push_back(use_last && bi == nbeats - 1);
    end
    run(name, 64'h0000_0008_0000_0000 + 64'($urandom), size, 30000);
    for (int r = 0; r < NROW; r++)
      check($sformatf("%s row%0d", name, r), res_mem[r], gold[r]);
  endtask

  typedef struct {
    logic [10:0] src, dst;
    logic        vld;
    logic [31:0] w, f, r;
    int          nwr;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [7];

  initial begin
    int d0, rs0, rd0, wr0;
    logic [511:0] b;

    begin : watchdog_fork
    end
    areset = 1'b1; ap_start = 1'b0; ctrl_instruction = '0;
    ctrl_addr_offset = 64'h0000_0100_0000_0040;
    for (int r = 0; r < NROW; r++) begin feat_mem[r] = '0; res_mem[r] = '0; end

    tv[0] = '{11'd3,  11'd5,  1'b1, 32'd2,          32'd7,          32'd1,          1, 32'd15};
    tv[1] = '{11'd1,  11'd2,  1'b1, 32'd1,          32'd1,          32'h7FFF_FFFF,  1,
              SAT ? 32'h7FFF_FFFF : 32'h8000_0000};
    tv[2] = '{11'd6,  11'd9,  1'b1, 32'hFFFF_FFFD,  32'd5,          32'd100,        1, 32'd85};
    tv[3] = '{11'd8,  11'd10, 1'b1, 32'h0001_0000,  32'h0001_0000,  32'd5,          1,
              SAT ? 32'h7FFF_FFFF : 32'd5};
    tv[4] = '{11'd11, 11'd12, 1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1,
              SAT ? 32'h7FFF_FFFF : 32'h8000_0000};
    tv[5] = '{11'd13, 11'd14, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'h8000_0000,  1,
              SAT ? 32'h8000_0000 : 32'h7FFF_FFFF};
    tv[6] = '{11'd15, 11'd16, 1'b0, 32'd4,          32'd4,          32'd4,          0, 32'd4};

    // Reset state
    tick(3);
    check("reset ctl", {ap_done, read_start, data_tready, b0_avalid, b0_addr, b1_avalid,
                        b1_addr, w_valid, w_addr, dram_xfer_start_addr,
                        dram_xfer_size_in_bytes}, '0);
    check("reset wdata", w_data, '0);
    areset = 1'b0;
    tick(2);

    // size == 0: immediate done, no reader or buffer traffic
    d0 = n_done; rs0 = n_rs; rd0 = n_rd0 + n_rd1; wr0 = n_wr;
    start(64'h1234, 32'd0);
    check("size0 done cycle", ap_done, 1'b1);
    tick(1);
    check("size0 done pulse width", ap_done, 1'b0);
    tick(4);
    check("size0 done count", n_done - d0, 1);
    check("size0 read_start", n_rs - rs0, 0);
    check("size0 buffer traffic", (n_rd0 + n_rd1 - rd0) + (n_wr - wr0), 0);

    // Single-edge vectors
    for (int i = 0; i < 7; i++) begin
      feat_mem[tv[i].src[5:0]] = {16{tv[i].f}};
      res_mem[tv[i].dst[5:0]]  = {16{tv[i].r}};
      b = '0;
      b[63:0] = mk_edge(tv[i].src, tv[i].dst, tv[i].vld, tv[i].w, 9'h1A5);
      sq_data.push_back(b);
      sq_last.push_back(1'b1);
      wr_addr_log.delete();
      wr0 = n_wr;
      run($sformatf("vec%0d", i), 64'h4000 + 64'(i * 64), 32'd64, 500);
      check($sformatf("vec%0d write count", i), n_wr - wr0, tv[i].nwr);
      check($sformatf("vec%0d row", i), res_mem[tv[i].dst[5:0]], {16{tv[i].exp}});
      if (tv[i].nwr == 1 && wr_addr_log.size() > 0)
        check($sformatf("vec%0d write addr", i), wr_addr_log[0], tv[i].dst);
    end

    // Two edges to the same dst, returns arriving in different cycles
    lat0 = 4; lat1 = 2;
    feat_mem[3] = {16{32'd10}};
    feat_mem[4] = {16{32'd20}};
    res_mem[5]  = '0;
    b = '0;
    b[63:0]   = mk_edge(11'd3, 11'd5, 1'b1, 32'd1, 9'd0);
    b[127:64] = mk_edge(11'd4, 11'd5, 1'b1, 32'd1, 9'd0);
    sq_data.push_back(b);
    sq_last.push_back(1'b0);
    wr_addr_log.delete(); wr_data_log.delete();
    rd0 = n_rd1;
    run("accum", 64'h8000, 32'd40, 500);
    check("accum writes", wr_data_log.size(), 2);
    check("accum reads", n_rd1 - rd0, 2);
    if (wr_data_log.size() == 2) begin
      check("accum first", wr_data_log[0], {16{32'd10}});
      check("accum second", wr_data_log[1], {16{32'd30}});
      check("accum addrs", {wr_addr_log[0], wr_addr_log[1]}, {11'd5, 11'd5});
    end

    // Randomized streams against the reference model
    lat0 = 4; lat1 = 4;
    random_run("rand27", 27, 32'd64 * 40, 1'b1);
    lat0 = 5; lat1 = 2;
    random_run("rand4", 4, 32'd64 * 4 - 32'd24, 1'b0);

    // Reset during WAIT, then a full pass
    lat0 = 4; lat1 = 4;
    feat_mem[3] = {16{32'd7}};
    res_mem[5]  = {16{32'd1}};
    b = '0;
    b[63:0] = mk_edge(11'd3, 11'd5, 1'b1, 32'd2, 9'd0);
    sq_data.push_back(b);
    sq_last.push_back(1'b1);
    start(64'hA000, 32'd64);
    begin
      int k;
      k = 0;
      while (!b0_avalid && k < 100) begin tick(1); k++; end
      check("rst issue seen", b0_avalid, 1'b1);
    end
    tick(1);
    areset = 1'b1;
    wr0 = n_wr;
    tick(1);
    check("rst ctl zero", {ap_done, read_start, data_tready, b0_avalid, b0_addr, b1_avalid,
                           b1_addr, w_valid, w_addr, dram_xfer_start_addr,
                           dram_xfer_size_in_bytes}, '0);
    areset = 1'b0;
    tick(10);
    check("rst no write", n_wr - wr0, 0);
    check("rst row untouched", res_mem[5], {16{32'd1}});
    sq_data.push_back(b);
    sq_last.push_back(1'b1);
    run("after rst", 64'hB000, 32'd64, 500);
    check("after rst row", res_mem[5], {16{32'd15}});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
